error_flag_gen: RTL and testbench



---
 rtl/can_error_pkg.sv | 22 ++
 rtl/equal_polarity_counter.sv | 51 +++++
 rtl/error_flag_gen.sv | 150 +++++++++++++++
 tb/tb_error_flag_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/can_error_pkg.sv
// Shared CAN error-frame definitions used by the error flag generator and the
// error delimiter stage.
//   error_flag_state_t : error flag FSM state encoding
//   DOMINANT/RECESSIVE : bus bit polarities
//   ERROR_FLAG_LEN     : default number of error flag bits
//   ERROR_FLAG_CNT_W   : default width of the flag bit counter
package can_error_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    ACTIVE_FLAG  = 2'b01,
    PASSIVE_FLAG = 2'b10,
    COMPLETE     = 2'b11
  } error_flag_state_t;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  localparam int unsigned ERROR_FLAG_LEN   = 6;
  localparam int unsigned ERROR_FLAG_CNT_W = 4;

endpackage

// File: rtl/equal_polarity_counter.sv
// Counts consecutive equal-polarity bus samples for the passive error flag.
// The run restarts at 1 whenever the sampled bit differs from the previous
// one (or the counter is empty).
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   clear          : synchronous clear of count and last polarity
//   step           : count one sample (bit sample point while passive)
//   bit_in         : sampled bus bit
//   count          : current run length (registered)
//   next_count_c   : run length after this step (combinational)
//   done_c         : this step completes a run of FLAG_LEN (combinational)
module equal_polarity_counter
  import can_error_pkg::*;
#(
  parameter int unsigned FLAG_LEN = ERROR_FLAG_LEN,
  parameter int unsigned CNT_W    = ERROR_FLAG_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             step,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] next_count_c,
  output logic             done_c
);

  logic last_pol;
  logic restart_c;

  // A run restarts on an empty counter or on a polarity change.
  always_comb begin
    restart_c    = (count == '0) || (bit_in != last_pol);
    next_count_c = restart_c ? CNT_W'(1) : count + CNT_W'(1);
    done_c       = step && !restart_c && (count == CNT_W'(FLAG_LEN - 1));
  end

  // Run length and polarity of the current run.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count    <= '0;
      last_pol <= 1'b0;
    end else if (step) begin
      count <= next_count_c;
      if (restart_c) begin
        last_pol <= bit_in;
      end
    end
  end

endmodule

// File: rtl/error_flag_gen.sv
// CAN error flag generator. On an error request an error-active node drives
// FLAG_LEN dominant bits; an error-passive node drives recessive and waits
// for FLAG_LEN consecutive equal-polarity bus samples. Completion is signalled
// to the error delimiter with a one-cycle error_flag_complete pulse.
// Optional build macro: ERROR_FLAG_BIT_MON_EN enables the flag_bit_error
// monitor (recessive sampled while an active flag drives dominant).
// Ports:
//   clock, reset_n       : clock and synchronous active-low reset
//   enable               : block enable, low acts as synchronous reset
//   sample_point         : one-cycle strobe at the bit sample point
//   error_detected       : one-cycle request to start an error flag
//   error_passive        : fault-confinement state, latched at flag start
//   bus_bit              : sampled bus value (1 = recessive)
//   error_flag_bit       : bit to drive onto the bus (0 = dominant)
//   bit_counter          : current flag bit count
//   error_flag_busy      : flag in progress
//   error_flag_complete  : one-cycle completion pulse
//   flag_bit_error       : one-cycle monitor pulse (0 unless monitor built)
module error_flag_gen
  import can_error_pkg::*;
#(
  parameter int unsigned FLAG_LEN = ERROR_FLAG_LEN,
  parameter int unsigned CNT_W    = ERROR_FLAG_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sample_point,
  input  logic             error_detected,
  input  logic             error_passive,
  input  logic             bus_bit,
  output logic             error_flag_bit,
  output logic [CNT_W-1:0] bit_counter,
  output logic             error_flag_busy,
  output logic             error_flag_complete,
  output logic             flag_bit_error
);

  error_flag_state_t state;
  logic              mode;

  logic              run_clear;
  logic              run_step;
  logic [CNT_W-1:0]  run_count;
  logic [CNT_W-1:0]  run_next_c;
  logic              run_done_c;

  // The equal-polarity run only lives while a passive flag is in progress.
  assign run_clear = !enable || (state != PASSIVE_FLAG);
  assign run_step  = sample_point && (state == PASSIVE_FLAG);

  equal_polarity_counter #(
    .FLAG_LEN (FLAG_LEN),
    .CNT_W    (CNT_W)
  ) u_run (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (run_clear),
    .step         (run_step),
    .bit_in       (bus_bit),
    .count        (run_count),
    .next_count_c (run_next_c),
    .done_c       (run_done_c)
  );

  // Error flag FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n || !enable) begin
      state               <= IDLE;
      mode                <= 1'b0;
      error_flag_bit      <= RECESSIVE;
      bit_counter         <= '0;
      error_flag_busy     <= 1'b0;
      error_flag_complete <= 1'b0;
    end else begin
      error_flag_complete <= 1'b0;
      case (state)
        IDLE: begin
          error_flag_bit <= RECESSIVE;
          bit_counter    <= '0;
          if (error_detected) begin
            mode            <= error_passive;
            error_flag_busy <= 1'b1;
            if (error_passive) begin
              state          <= PASSIVE_FLAG;
              error_flag_bit <= RECESSIVE;
            end else begin
              state          <= ACTIVE_FLAG;
              error_flag_bit <= DOMINANT;
            end
          end
        end

        ACTIVE_FLAG: begin
          error_flag_bit <= mode ? RECESSIVE : DOMINANT;
          if (sample_point) begin
            if (bit_counter == CNT_W'(FLAG_LEN - 1)) begin
              state               <= COMPLETE;
              bit_counter         <= CNT_W'(FLAG_LEN);
              error_flag_bit      <= RECESSIVE;
              error_flag_busy     <= 1'b0;
              error_flag_complete <= 1'b1;
            end else begin
              bit_counter <= bit_counter + CNT_W'(1);
            end
          end
        end

        PASSIVE_FLAG: begin
          error_flag_bit <= RECESSIVE;
          if (sample_point) begin
            bit_counter <= run_next_c;
            if (run_done_c) begin
              state               <= COMPLETE;
              error_flag_busy     <= 1'b0;
              error_flag_complete <= 1'b1;
            end
          end
        end

        COMPLETE: begin
          state          <= IDLE;
          bit_counter    <= '0;
          error_flag_bit <= RECESSIVE;
        end

        default: begin
          state           <= IDLE;
          bit_counter     <= '0;
          error_flag_bit  <= RECESSIVE;
          error_flag_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef ERROR_FLAG_BIT_MON_EN
  // Recessive seen on the bus while we drive a dominant active flag.
  always_ff @(posedge clock) begin
    if (!reset_n || !enable) begin
      flag_bit_error <= 1'b0;
    end else begin
      flag_bit_error <= (state == ACTIVE_FLAG) && sample_point && (bus_bit == RECESSIVE);
    end
  end
`else
  assign flag_bit_error = 1'b0;
`endif

endmodule

// File: tb/tb_error_flag_gen.sv
// Self-checking bench for error_flag_gen: directed vector table, hand-written
// corner-case sequences and randomized stimulus checked against a behavioural
// model built on the sampled-bit history.
module tb_error_flag_gen;

  localparam int unsigned LEN = 6;
  localparam int unsigned CW  = 4;

  logic          clock = 1'b0;
  logic          reset_n, enable, sample_point, error_detected, error_passive, bus_bit;
  logic          error_flag_bit, error_flag_busy, error_flag_complete, flag_bit_error;
  logic [CW-1:0] bit_counter;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_complete_seen = 0;
  int n_fbe_seen      = 0;

  error_flag_gen #(.FLAG_LEN(LEN), .CNT_W(CW)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .enable              (enable),
    .sample_point        (sample_point),
    .error_detected      (error_detected),
    .error_passive       (error_passive),
    .bus_bit             (bus_bit),
    .error_flag_bit      (error_flag_bit),
    .bit_counter         (bit_counter),
    .error_flag_busy     (error_flag_busy),
    .error_flag_complete (error_flag_complete),
    .flag_bit_error      (flag_bit_error)
  );

  always #5 clock = ~clock;

  // Reference model: phase 0 idle, 1 flag running, 2 completion cycle.
  int   m_phase   = 0;
  logic m_passive = 1'b0;
  int   m_nsamp   = 0;
  int   m_cnt     = 0;
  logic m_fbe     = 1'b0;
  logic m_hist[$];

  function automatic int trailing_run();
    int n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] == m_hist[m_hist.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_step();
    m_fbe = 1'b0;
    if (!reset_n || !enable) begin
      m_phase = 0; m_cnt = 0; m_nsamp = 0; m_passive = 1'b0;
      m_hist.delete();
    end else begin
      case (m_phase)
        0: if (error_detected) begin
          m_phase = 1; m_passive = error_passive; m_cnt = 0; m_nsamp = 0;
          m_hist.delete();
        end
        1: if (sample_point) begin
          m_nsamp++;
          m_hist.push_back(bus_bit);
          if (m_hist.size() > 32) void'(m_hist.pop_front());
          if (!m_passive && bus_bit) m_fbe = 1'b1;
          m_cnt = m_passive ? trailing_run() : m_nsamp;
          if (m_cnt == LEN) m_phase = 2;
        end
        default: begin m_phase = 0; m_cnt = 0; end
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it.
  task automatic cyc(input logic r, input logic e, input logic s, input logic d,
                     input logic p, input logic b);
    logic exp_fbe;
    reset_n = r; enable = e; sample_point = s; error_detected = d;
    error_passive = p; bus_bit = b;
    @(posedge clock);
    model_step();
    #1;
`ifdef ERROR_FLAG_BIT_MON_EN
    exp_fbe = m_fbe;
`else
    exp_fbe = 1'b0;
`endif
    chk("flag_bit", int'(error_flag_bit), (m_phase == 1 && !m_passive) ? 0 : 1);
    chk("bit_counter", int'(bit_counter), m_cnt);
    chk("busy", int'(error_flag_busy), (m_phase == 1) ? 1 : 0);
    chk("complete", int'(error_flag_complete), (m_phase == 2) ? 1 : 0);
    chk("flag_bit_error", int'(flag_bit_error), int'(exp_fbe));
    if (error_flag_complete) n_complete_seen++;
    if (flag_bit_error) n_fbe_seen++;
  endtask

  typedef struct {
    logic r, e, s, d, p, b;
    logic e_bit;
    int   e_cnt;
    logic e_busy, e_cmp;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, e, s, d, p, b, input logic eb, input int ec,
                      input logic ebusy, input logic ecmp);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.d = d; v.p = p; v.b = b;
    v.e_bit = eb; v.e_cnt = ec; v.e_busy = ebusy; v.e_cmp = ecmp;
    vecs.push_back(v);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 1);
  endtask

  initial begin
    logic bus_r;
    int   c0, f0, cnt_hold;

    //   r  e  s  d  p  b    bit cnt busy cmp
    addv(0, 1, 0, 0, 0, 1,   1,  0,  0,   0);   // reset
    addv(1, 1, 0, 1, 0, 1,   0,  0,  1,   0);   // active start
    addv(1, 1, 1, 0, 0, 0,   0,  1,  1,   0);
    addv(1, 1, 0, 0, 0, 0,   0,  1,  1,   0);   // no sample: hold
    addv(1, 1, 1, 0, 0, 0,   0,  2,  1,   0);
    addv(1, 1, 1, 1, 0, 0,   0,  3,  1,   0);   // error_detected ignored
    addv(1, 1, 1, 0, 1, 0,   0,  4,  1,   0);   // error_passive ignored
    addv(1, 1, 1, 0, 0, 0,   0,  5,  1,   0);
    addv(1, 1, 1, 1, 0, 0,   1,  6,  0,   1);   // 6th sample: complete
    addv(1, 1, 0, 1, 0, 1,   1,  0,  0,   0);   // request in COMPLETE ignored
    addv(1, 1, 0, 0, 0, 1,   1,  0,  0,   0);
    addv(1, 1, 0, 1, 1, 1,   1,  0,  1,   0);   // passive start
    addv(1, 1, 1, 0, 0, 0,   1,  1,  1,   0);
    addv(1, 1, 1, 0, 1, 0,   1,  2,  1,   0);
    addv(1, 1, 1, 0, 0, 0,   1,  3,  1,   0);
    addv(1, 1, 1, 0, 1, 1,   1,  1,  1,   0);   // polarity change restarts
    addv(1, 1, 1, 0, 0, 1,   1,  2,  1,   0);
    addv(1, 1, 1, 0, 1, 1,   1,  3,  1,   0);
    addv(1, 1, 1, 0, 0, 1,   1,  4,  1,   0);
    addv(1, 1, 1, 0, 1, 1,   1,  5,  1,   0);
    addv(1, 1, 1, 0, 0, 1,   1,  6,  0,   1);   // 9th sample: complete
    addv(1, 1, 0, 0, 0, 1,   1,  0,  0,   0);

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].d, vecs[i].p, vecs[i].b);
      chk("tbl_flag_bit", int'(error_flag_bit), int'(vecs[i].e_bit));
      chk("tbl_bit_counter", int'(bit_counter), vecs[i].e_cnt);
      chk("tbl_busy", int'(error_flag_busy), int'(vecs[i].e_busy));
      chk("tbl_complete", int'(error_flag_complete), int'(vecs[i].e_cmp));
    end

    // Reset mid-flag after three active bits: abort without completion.
    c0 = n_complete_seen;
    cyc(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("rst_abort_cnt", int'(bit_counter), 0);
    chk("rst_abort_bit", int'(error_flag_bit), 1);
    idle_cycles(8);
    chk("rst_abort_no_complete", n_complete_seen - c0, 0);

    // Same abort through enable.
    cyc(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("en_abort_busy", int'(error_flag_busy), 0);
    idle_cycles(8);
    chk("en_abort_no_complete", n_complete_seen - c0, 0);

    // Sample gating: counter frozen, then consecutive sample points count each.
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cnt_hold = int'(bit_counter);
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 1, 0, 0);
    chk("gate_frozen", int'(bit_counter), cnt_hold);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0);
    chk("gate_complete", int'(error_flag_complete), 1);
    idle_cycles(2);

    // Recessive at the 3rd active sample point.
    c0 = n_complete_seen; f0 = n_fbe_seen;
    cyc(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0, (i == 2) ? 1'b1 : 1'b0);
    chk("mon_complete_after_6", int'(error_flag_complete), 1);
    idle_cycles(2);
    chk("mon_single_complete", n_complete_seen - c0, 1);
`ifdef ERROR_FLAG_BIT_MON_EN
    chk("mon_pulses", n_fbe_seen - f0, 1);
`else
    chk("mon_pulses", n_fbe_seen - f0, 0);
`endif

    // Passive flag never raises the monitor even with recessive samples.
    f0 = n_fbe_seen;
    cyc(1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0, 1);
    chk("passive_complete", int'(error_flag_complete), 1);
    chk("passive_no_mon", n_fbe_seen - f0, 0);
    idle_cycles(2);

    // Randomized traffic against the model.
    bus_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) bus_r = ~bus_r;
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 249) != 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 1)),
          bus_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
